// File: rtl/demux_1to2_buf.sv
// 1-to-2 demultiplexer with one registered output slot per port.
// Each slot refills in the same cycle it drains, and counts delivered words.
module demux_1to2_buf #(
    parameter int WIDTH = 32,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Sel,
    input  logic [WIDTH-1:0] A,
    input  logic             A_valid,
    output logic             A_ready,
    output logic [WIDTH-1:0] B,
    output logic             B_valid,
    input  logic             B_ready,
    output logic [WIDTH-1:0] C,
    output logic             C_valid,
    input  logic             C_ready,
    output logic [CW-1:0]    B_count,
    output logic [CW-1:0]    C_count
);

    logic b_space;
    logic c_space;
    logic in_fire;
    logic b_fill;
    logic c_fill;
    logic b_drain;
    logic c_drain;

    // A slot can take a word if it is empty or is being emptied this cycle.
    // While reset is asserted the slots are treated as empty.
    always_comb begin
        b_space = !B_valid || B_ready;
        c_space = !C_valid || C_ready;
        A_ready = !rst_n || (Sel ? c_space : b_space);
        in_fire = A_valid && A_ready;
        b_fill  = in_fire && !Sel;
        c_fill  = in_fire && Sel;
        b_drain = B_valid && B_ready;
        c_drain = C_valid && C_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            B       <= '0;
            B_valid <= 1'b0;
            B_count <= '0;
        end else begin
            if (b_fill) begin
                B       <= A;
                B_valid <= 1'b1;
            end else if (b_drain) begin
                B_valid <= 1'b0;
            end
            if (b_drain) begin
                B_count <= B_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            C       <= '0;
            C_valid <= 1'b0;
            C_count <= '0;
        end else begin
            if (c_fill) begin
                C       <= A;
                C_valid <= 1'b1;
            end else if (c_drain) begin
                C_valid <= 1'b0;
            end
            if (c_drain) begin
                C_count <= C_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Scoreboard bench for demux_1to2_buf: each accepted word is queued for its port
// and compared when the port presents it; slot valid, A_ready and counts are modelled too.
module tb_demux_1to2_buf;

    localparam int WIDTH = 32;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Sel;
    logic [WIDTH-1:0] A;
    logic             A_valid;
    logic             A_ready;
    logic [WIDTH-1:0] B;
    logic             B_valid;
    logic             B_ready;
    logic [WIDTH-1:0] C;
    logic             C_valid;
    logic             C_ready;
    logic [CW-1:0]    B_count;
    logic [CW-1:0]    C_count;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] qB[$];
    logic [WIDTH-1:0] qC[$];
    logic [WIDTH-1:0] lastB = '0;
    logic [WIDTH-1:0] lastC = '0;
    logic [CW-1:0]    bCnt  = '0;
    logic [CW-1:0]    cCnt  = '0;

    demux_1to2_buf #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Sel     (Sel),
        .A       (A),
        .A_valid (A_valid),
        .A_ready (A_ready),
        .B       (B),
        .B_valid (B_valid),
        .B_ready (B_ready),
        .C       (C),
        .C_valid (C_valid),
        .C_ready (C_ready),
        .B_count (B_count),
        .C_count (C_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle just after a falling edge, compare against the model,
    // then advance the model to what the coming rising edge should produce.
    task automatic applyStimulus(input logic rn, input logic av, input logic sel,
                                 input logic [WIDTH-1:0] a, input logic br, input logic cr);
        logic expReady;
        logic [WIDTH-1:0] expB;
        logic [WIDTH-1:0] expC;
        rst_n   = rn;
        A_valid = av;
        Sel     = sel;
        A       = a;
        B_ready = br;
        C_ready = cr;
        #1;
        expReady = !rn || (sel ? (qC.size() == 0 || cr) : (qB.size() == 0 || br));
        if (qB.size() != 0) expB = qB[0];
        else                expB = lastB;
        if (qC.size() != 0) expC = qC[0];
        else                expC = lastC;
        checkOutput("a_ready", A_ready, expReady);
        checkOutput("b_valid", B_valid, qB.size() != 0);
        checkOutput("c_valid", C_valid, qC.size() != 0);
        checkOutput("b_data", B, expB);
        checkOutput("c_data", C, expC);
        checkOutput("b_count", B_count, bCnt);
        checkOutput("c_count", C_count, cCnt);
        if (!rn) begin
            qB.delete();
            qC.delete();
            lastB = '0;
            lastC = '0;
            bCnt  = '0;
            cCnt  = '0;
        end else begin
            if (br && qB.size() != 0) begin
                void'(qB.pop_front());
                bCnt++;
            end
            if (cr && qC.size() != 0) begin
                void'(qC.pop_front());
                cCnt++;
            end
            if (av && expReady) begin
                if (sel) begin
                    qC.push_back(a);
                    lastC = a;
                end else begin
                    qB.push_back(a);
                    lastB = a;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        A_valid = 1'b0;
        Sel     = 1'b0;
        A       = '0;
        B_ready = 1'b0;
        C_ready = 1'b0;
        @(negedge clk);

        // Reset state, with a word offered during reset that must be dropped
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);

        // Single word to B, then B stalls while A keeps offering to B
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_00AA, 1'b0, 1'b0);
        checkOutput("first_b_data", B, 32'h0000_00AA);
        checkOutput("first_b_count", B_count, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_00BB, 1'b0, 1'b0);

        // Stalled B must not block a word for C
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("c_bypass_data", C, 32'h1234_5678);

        // Release B with a simultaneous refill
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_00BB, 1'b1, 1'b0);
        checkOutput("release_b_count", B_count, 1);
        checkOutput("refill_b_data", B, 32'h0000_00BB);

        // Reset with both slots full discards everything
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0033, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("post_rst_b_valid", B_valid, 0);
        checkOutput("post_rst_c_valid", C_valid, 0);
        checkOutput("post_rst_b_count", B_count, 0);

        // 300 back-to-back words through B, counter wraps to 44
        for (int w = 1; w <= 300; w++)
            applyStimulus(1'b1, 1'b1, 1'b0, WIDTH'(w), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("wrap_b_count", B_count, 44);
        checkOutput("wrap_b_last", B, 300);

        // Random traffic on both ports
        for (int i = 0; i < 10000; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("final_b_empty", B_valid, 0);
        checkOutput("final_c_empty", C_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_1to2_buf.md
DEMUX_1TO2_BUF -- requirements
Module: demux_1to2_buf

Parameters
REQ-001 SHALL provide parameter WIDTH, default 32, data word width.
REQ-002 SHALL provide parameter CW, default 8, per-port transfer counter width.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 Sel  input  1  destination select for the input word (0 -> port B, 1 -> port C).
REQ-006 A  input  WIDTH  input data word.
REQ-007 A_valid  input  1  A and Sel valid this cycle.
REQ-008 A_ready  output  1  block accepts A this cycle.
REQ-009 B  output  WIDTH  port-B data word.
REQ-010 B_valid  output  1  B holds a word.
REQ-011 B_ready  input  1  port-B consumer accepts.
REQ-012 C  output  WIDTH  port-C data word.
REQ-013 C_valid  output  1  C holds a word.
REQ-014 C_ready  input  1  port-C consumer accepts.
REQ-015 B_count  output  CW  words delivered on port B (handshakes completed).
REQ-016 C_count  output  CW  words delivered on port C.

Function
REQ-017 Each output port SHALL own one registered slot (data + valid); a slot state is EMPTY (valid=0) or FULL (valid=1).
REQ-018 Input transfer SHALL occur when A_valid & A_ready; output transfer on a port SHALL occur when that port's valid & ready.
REQ-019 A_ready SHALL be combinational: (Sel==0) ? (!B_valid | B_ready) : (!C_valid | C_ready); independent of A_valid.
REQ-020 On input transfer the word SHALL appear on the selected port with valid=1 on the next clock edge (latency 1 cycle); the unselected port's slot SHALL be unaffected.
REQ-021 Slot transitions: EMPTY -> FULL on input fill; FULL -> EMPTY on output transfer with no fill; FULL -> FULL with new word on simultaneous output transfer and fill (no bubble, no loss).
REQ-022 While a slot is FULL and not drained, its data SHALL remain stable and valid SHALL stay 1.
REQ-023 Sel and A SHALL be ignored when A_valid=0; no slot or counter changes.
REQ-024 Both ports SHALL drain independently in the same cycle; a stalled port SHALL NOT block input destined for the other port.
REQ-025 B_count/C_count SHALL increment by 1 on each output transfer of their port and wrap from 2^CW-1 to 0 without flag.
REQ-026 Word order per port SHALL be preserved; no word SHALL be duplicated or dropped.
REQ-027 Output data of an EMPTY slot SHALL retain the last value held (no zeroing except at reset).

Reset
REQ-028 When rst_n=0 at a rising edge: B, C = 0; B_valid, C_valid = 0; B_count, C_count = 0.
REQ-029 Reset SHALL take priority over any simultaneous transfer; words held at reset are discarded.
REQ-030 During reset, A_ready SHALL follow REQ-019 using reset slot state (i.e. 1), but accepted words SHALL be discarded.
REQ-031 First transfer after reset SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-032 Reset, then A=32'h0000_00AA, Sel=0, A_valid=1 one cycle, B_ready=0 -> next cycle B=32'h0000_00AA, B_valid=1, C_valid=0, B_count=0.
REQ-033 B slot FULL, B_ready=0, Sel=0, A_valid=1 -> A_ready=0; B holds value for 5 cycles; then B_ready=1 -> B_count=1 and A_ready=1 in the same cycle.
REQ-034 B FULL stalled, Sel=1, A=32'h1234_5678, A_valid=1, C empty -> A_ready=1; next cycle C=32'h1234_5678, C_valid=1; B unchanged.
REQ-035 B_ready=1 held, A_valid=1, Sel=0, words 1..300 back-to-back -> one word per cycle, in order, no bubbles; B_count=300 mod 256=44.
REQ-036 Both slots FULL, rst_n=0 one cycle with A_valid=1 -> B_valid=C_valid=0, counts 0, no word emerges afterward.
REQ-037 Random A_valid/Sel/B_ready/C_ready for 10000 cycles vs. per-port scoreboard -> zero order, loss or duplication errors; counts match scoreboard mod 2^CW.
